// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and the CDB broadcast type
// Producer IDs fix each functional unit's slot on the CDB request vector.
package riscv_pkg;

    localparam int XLEN              = 32;
    localparam int TAG_WIDTH         = 6;
    localparam int NUM_CDB_PRODUCERS = 4;

    localparam int CDB_ID_ALU0 = 0;
    localparam int CDB_ID_ALU1 = 1;
    localparam int CDB_ID_MUL  = 2;
    localparam int CDB_ID_LSU  = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
        logic                 exception;
    } cdb_bcast_s;

    function automatic int rr_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot arbiter
// Scans from ptr upward with wraparound; shared by CDB arbitration and RS issue select.
module rr_arbiter
    import riscv_pkg::*;
#(
    parameter  int N     = 4,
    localparam int PTR_W = rr_ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    localparam int W2 = 2 * N;

    logic [W2-1:0] mask;
    logic [W2-1:0] dbl;
    logic          found;

    // Doubling the request vector turns the wrapped scan into a plain lowest-bit search.
    always_comb begin
        mask  = ~((W2'(1) << ptr) - W2'(1));
        dbl   = {req, req} & mask;
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && dbl[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && dbl[N+j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB round-robin arbiter with registered broadcast
// Optional CDB_PERF_CNT_EN adds saturating conflict/busy cycle counters.
module cdb_arbiter
    import riscv_pkg::*;
#(
    parameter int N_PROD = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = riscv_pkg::TAG_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PROD-1:0]          req,
    input  logic [N_PROD*TAG_W-1:0]    tag_in,
    input  logic [N_PROD*DATA_W-1:0]   data_in,
    input  logic [N_PROD-1:0]          exception_in,
    output logic [N_PROD-1:0]          grant,
    input  logic                       flush,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic                       cdb_exception
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]                perf_conflict_cnt,
    output logic [31:0]                perf_busy_cnt
`endif
);

    localparam int PTR_W = rr_ptr_width(N_PROD);

    // Same layout as cdb_bcast_s, sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              exception;
    } bcast_t;

    bcast_t            bcast_q, bcast_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_PROD-1:0] arb_req;

    assign arb_req = (rst || flush) ? '0 : req;

    rr_arbiter #(.N(N_PROD)) u_rr (
        .req   (arb_req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        bcast_d       = bcast_q;
        bcast_d.valid = 1'b0;
        ptr_d         = ptr_q;
        for (int i = 0; i < N_PROD; i++) begin
            if (grant[i]) begin
                bcast_d.valid     = 1'b1;
                bcast_d.tag       = tag_in[i*TAG_W +: TAG_W];
                bcast_d.data      = data_in[i*DATA_W +: DATA_W];
                bcast_d.exception = exception_in[i];
                ptr_d             = PTR_W'((i + 1) % N_PROD);
            end
        end
    end

`ifdef CDB_PERF_CNT_EN
    logic [31:0] conflict_q, busy_q;
    logic        conflict_inc, busy_inc;

    assign conflict_inc = !flush && ($countones(req) > 1);
    assign busy_inc     = |grant;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_q <= '0;
            ptr_q   <= '0;
`ifdef CDB_PERF_CNT_EN
            conflict_q <= '0;
            busy_q     <= '0;
`endif
        end else begin
            bcast_q <= bcast_d;
            ptr_q   <= ptr_d;
`ifdef CDB_PERF_CNT_EN
            if (conflict_inc && conflict_q != 32'hFFFF_FFFF) conflict_q <= conflict_q + 32'd1;
            if (busy_inc && busy_q != 32'hFFFF_FFFF)         busy_q     <= busy_q + 32'd1;
`endif
        end
    end

    assign cdb_valid     = bcast_q.valid;
    assign cdb_tag       = bcast_q.tag;
    assign cdb_data      = bcast_q.data;
    assign cdb_exception = bcast_q.exception;

`ifdef CDB_PERF_CNT_EN
    assign perf_conflict_cnt = conflict_q;
    assign perf_busy_cnt     = busy_q;
`endif

endmodule
